// File: rtl/msx_opl4_pkg.sv
// msx_opl4_pkg: shared sequencer state, FIFO entry layout and default port constants
package msx_opl4_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_RECOV} seq_state_e;
  typedef struct packed {
    logic [2:0] addr;
    logic [7:0] data;
  } fifo_entry_t;
  localparam logic [7:0] FM_BASE_DEF = 8'hC4;
  localparam logic [7:0] WAVE_BASE_DEF = 8'h7E;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int SETUP_CYC_DEF = 1;
  localparam int STROBE_CYC_DEF = 3;
  localparam int RECOV_CYC_DEF = 4;
endpackage

// File: rtl/msx_opl4_wfifo.sv
// msx_opl4_wfifo: posted-write buffer between the MSX bus side and the OPL4 sequencer
module msx_opl4_wfifo
  import msx_opl4_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  fifo_entry_t din,
  output fifo_entry_t dout,
  output logic        full,
  output logic        empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] count;
  logic do_push, do_pop;
  fifo_entry_t mem [DEPTH];
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rp];
  // storage array needs no reset; occupancy is tracked by count
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  // pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/msx_opl4_iobridge.sv
// msx_opl4_iobridge: MSX I/O to OPL4 bridge with posted writes; OPL4_WAVE_PORTS_EN enables the wave window
module msx_opl4_iobridge
  import msx_opl4_pkg::*;
#(
  parameter logic [7:0] FM_BASE = FM_BASE_DEF,
  parameter logic [7:0] WAVE_BASE = WAVE_BASE_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int SETUP_CYC = SETUP_CYC_DEF,
  parameter int STROBE_CYC = STROBE_CYC_DEF,
  parameter int RECOV_CYC = RECOV_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] msx_a,
  input  logic [7:0] msx_d_in,
  output logic [7:0] msx_d_out,
  input  logic       msx_iorq_n,
  input  logic       msx_rd_n,
  input  logic       msx_wr_n,
  output logic       msx_wait_n,
  output logic       msx_busdir,
  output logic [2:0] y_a,
  output logic       y_cs_n,
  output logic       y_rd_n,
  output logic       y_wr_n,
  output logic [7:0] y_d_out,
  output logic       y_d_oe,
  input  logic [7:0] y_d_in
);
`ifdef OPL4_WAVE_PORTS_EN
  localparam logic WAVE_EN = 1'b1;
`else
  localparam logic WAVE_EN = 1'b0;
`endif
  localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYC - 1);
  localparam logic [7:0] STROBE_LAST = 8'(STROBE_CYC - 1);
  localparam logic [7:0] RECOV_LAST = 8'(RECOV_CYC - 1);
  logic [1:0] iorq_q, rd_q, wr_q;
  logic seen, wr_pend, rd_req, cur_rd;
  logic hit_fm, hit_wave, hit, active, start, wr_start, rd_start, wr_block;
  logic push, pop, full, empty, last, rd_latch;
  logic [2:0] dec_a, rd_addr;
  logic [7:0] cnt;
  fifo_entry_t pend_entry, push_data, head;
  seq_state_e state;
  assign hit_fm = msx_a[7:2] == FM_BASE[7:2];
  assign hit_wave = WAVE_EN && (msx_a[7:1] == WAVE_BASE[7:1]);
  assign hit = hit_fm || hit_wave;
  assign dec_a = hit_fm ? {1'b1, msx_a[1:0]} : {2'b00, msx_a[0]};
  assign msx_busdir = !(!msx_iorq_n && !msx_rd_n && hit);
  assign active = !iorq_q[1] && (!rd_q[1] || !wr_q[1]);
  assign start = active && !seen && hit;
  assign wr_start = start && !wr_q[1];
  assign rd_start = start && wr_q[1];
  assign last = cnt == (state == ST_SETUP ? SETUP_LAST : state == ST_STROBE ? STROBE_LAST : RECOV_LAST);
  assign pop = state == ST_SETUP && last && !cur_rd;
  assign rd_latch = state == ST_STROBE && last && cur_rd;
  assign wr_block = wr_start && full && !pop;
  assign push = (wr_start && !wr_block) || (wr_pend && pop);
  assign push_data = wr_pend ? pend_entry : '{addr: dec_a, data: msx_d_in};
  assign msx_wait_n = !(wr_pend || wr_block || rd_req || rd_start);
  msx_opl4_wfifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .din(push_data),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  // two-flop synchronisers for the asynchronous MSX strobes
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      iorq_q <= '1;
      rd_q <= '1;
      wr_q <= '1;
    end else begin
      iorq_q <= {iorq_q[0], msx_iorq_n};
      rd_q <= {rd_q[0], msx_rd_n};
      wr_q <= {wr_q[0], msx_wr_n};
    end
  // MSX side: one start per strobe, stalled writes, pending read and returned data
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      seen <= 1'b0;
      wr_pend <= 1'b0;
      rd_req <= 1'b0;
      pend_entry <= '0;
      rd_addr <= '0;
      msx_d_out <= '0;
    end else begin
      seen <= active;
      wr_pend <= wr_block || (wr_pend && !pop);
      rd_req <= rd_start || (rd_req && !rd_latch);
      if (wr_block) pend_entry <= push_data;
      if (rd_start) rd_addr <= dec_a;
      if (rd_latch) msx_d_out <= y_d_in;
    end
  // OPL4 bus sequencer; buffered writes are served before a pending read
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt <= '0;
      cur_rd <= 1'b0;
      y_a <= '0;
      y_d_out <= '0;
      y_d_oe <= 1'b0;
      y_cs_n <= 1'b1;
      y_rd_n <= 1'b1;
      y_wr_n <= 1'b1;
    end else begin
      cnt <= (state == ST_IDLE || last) ? '0 : cnt + 8'd1;
      case (state)
        ST_IDLE:
          if (!empty || rd_req) begin
            state <= ST_SETUP;
            cur_rd <= empty;
            y_a <= empty ? rd_addr : head.addr;
            y_d_out <= empty ? y_d_out : head.data;
            y_d_oe <= !empty;
            y_cs_n <= 1'b0;
          end
        ST_SETUP:
          if (last) begin
            state <= ST_STROBE;
            y_wr_n <= cur_rd;
            y_rd_n <= !cur_rd;
          end
        ST_STROBE:
          if (last) begin
            state <= ST_RECOV;
            y_wr_n <= 1'b1;
            y_rd_n <= 1'b1;
            y_cs_n <= 1'b1;
            y_d_oe <= 1'b0;
          end
        default:
          if (last) state <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_msx_opl4_iobridge.sv
// tb_msx_opl4_iobridge: scoreboard bench for the MSX to OPL4 I/O bridge
module tb_msx_opl4_iobridge;
  localparam int SETUP_T = 24;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] msx_a = 8'h00, msx_d_in = 8'h00, y_d_in = 8'h00;
  logic msx_iorq_n = 1'b1, msx_rd_n = 1'b1, msx_wr_n = 1'b1;
  logic [7:0] msx_d_out, y_d_out;
  logic msx_wait_n, msx_busdir, y_cs_n, y_rd_n, y_wr_n, y_d_oe;
  logic [2:0] y_a;
  int n_cmp = 0, n_err = 0, cs_cnt = 0, wr_cnt = 0, rd_cnt = 0;
  logic [10:0] exp_q [$];
  logic [2:0] rd_exp_a = 3'b000;
  logic prev_cs = 1'b1, prev_wr = 1'b1, prev_rd = 1'b1;

  always #5 clk = ~clk;

  msx_opl4_iobridge #(.FIFO_DEPTH(4), .SETUP_CYC(SETUP_T)) u_dut (
    .clk(clk), .rst_n(rst_n), .msx_a(msx_a), .msx_d_in(msx_d_in), .msx_d_out(msx_d_out),
    .msx_iorq_n(msx_iorq_n), .msx_rd_n(msx_rd_n), .msx_wr_n(msx_wr_n),
    .msx_wait_n(msx_wait_n), .msx_busdir(msx_busdir), .y_a(y_a), .y_cs_n(y_cs_n),
    .y_rd_n(y_rd_n), .y_wr_n(y_wr_n), .y_d_out(y_d_out), .y_d_oe(y_d_oe), .y_d_in(y_d_in)
  );

  // OPL4-side scoreboard: every write strobe pops the oldest expected entry
  always @(negedge clk) begin
    logic [10:0] e;
    if (rst_n) begin
      if (!y_cs_n && prev_cs) cs_cnt++;
      if (!y_wr_n && prev_wr) begin
        wr_cnt++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL opl4_write_unexpected: got a=%b d=%h, required no write", y_a, y_d_out);
        end else begin
          e = exp_q.pop_front();
          if ({y_a, y_d_out, y_d_oe, y_cs_n} !== {e, 2'b10}) begin
            n_err++;
            $display("FAIL opl4_write: got a=%b d=%h oe=%b cs_n=%b, required a=%b d=%h oe=1 cs_n=0",
                     y_a, y_d_out, y_d_oe, y_cs_n, e[10:8], e[7:0]);
          end
        end
      end
      if (!y_rd_n && prev_rd) begin
        rd_cnt++;
        n_cmp++;
        if ({y_a, y_d_oe, y_cs_n, exp_q.size() == 0} !== {rd_exp_a, 3'b001}) begin
          n_err++;
          $display("FAIL opl4_read: got a=%b oe=%b cs_n=%b pending_writes=%0d, required a=%b oe=0 cs_n=0 pending_writes=0",
                   y_a, y_d_oe, y_cs_n, exp_q.size(), rd_exp_a);
        end
      end
    end
    prev_cs = y_cs_n;
    prev_wr = y_wr_n;
    prev_rd = y_rd_n;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic io_write(input logic [7:0] a, input logic [7:0] d, output logic saw_wait,
                          output logic bus_hi, output int wr_rel);
    tick();
    msx_a = a;
    msx_d_in = d;
    msx_iorq_n = 1'b0;
    msx_wr_n = 1'b0;
    saw_wait = 1'b0;
    bus_hi = 1'b1;
    wr_rel = -1;
    repeat (2) begin
      tick();
      if (!msx_wait_n) saw_wait = 1'b1;
      if (!msx_busdir) bus_hi = 1'b0;
    end
    for (int i = 0; i < 400 && !msx_wait_n; i++) begin
      tick();
      if (!msx_busdir) bus_hi = 1'b0;
      if (msx_wait_n) wr_rel = wr_cnt;
    end
    if (!msx_wait_n) begin
      n_cmp++;
      n_err++;
      $display("FAIL write_wait_timeout: got wait_n=0 after 400 cycles, required release");
    end
    msx_iorq_n = 1'b1;
    msx_wr_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic io_read(input logic [7:0] a, output logic [7:0] d, output logic [7:0] d_hold,
                         output logic saw_wait, output logic bus_all_lo, output logic bus_any_lo,
                         output logic bus_after);
    tick();
    msx_a = a;
    msx_iorq_n = 1'b0;
    msx_rd_n = 1'b0;
    saw_wait = 1'b0;
    bus_all_lo = 1'b1;
    bus_any_lo = 1'b0;
    for (int i = 0; i < 402 && (i < 2 || !msx_wait_n); i++) begin
      tick();
      if (!msx_wait_n) saw_wait = 1'b1;
      if (msx_busdir) bus_all_lo = 1'b0;
      else bus_any_lo = 1'b1;
    end
    if (!msx_wait_n) begin
      n_cmp++;
      n_err++;
      $display("FAIL read_wait_timeout: got wait_n=0 after 400 cycles, required release");
    end
    d = msx_d_out;
    repeat (2) tick();
    d_hold = msx_d_out;
    msx_iorq_n = 1'b1;
    msx_rd_n = 1'b1;
    #1;
    bus_after = msx_busdir;
    repeat (2) tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d writes still outstanding, required 0", exp_q.size());
    end
    repeat (40) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({y_cs_n, y_rd_n, y_wr_n, y_d_oe, y_a, y_d_out, msx_wait_n, msx_d_out} !== {4'b1110, 3'b000, 8'h00, 1'b1, 8'h00}) begin
      n_err++;
      $display("FAIL reset_values: got cs_n=%b rd_n=%b wr_n=%b oe=%b a=%b yd=%h wait_n=%b md=%h, required 1 1 1 0 000 00 1 00",
               y_cs_n, y_rd_n, y_wr_n, y_d_oe, y_a, y_d_out, msx_wait_n, msx_d_out);
    end
    rst_n = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if ({msx_wait_n, msx_busdir, y_cs_n} !== 3'b111) begin
      n_err++;
      $display("FAIL idle_after_reset: got wait_n=%b busdir=%b cs_n=%b, required 1 1 1", msx_wait_n, msx_busdir, y_cs_n);
    end
  endtask

  task automatic test_fm_writes();
    logic sw, bh;
    int rel, base;
    base = wr_cnt;
    exp_q.push_back({3'b100, 8'h01});
    io_write(8'hC4, 8'h01, sw, bh, rel);
    n_cmp++;
    if ({sw, bh} !== 2'b01) begin
      n_err++;
      $display("FAIL fm_wr_c4: got saw_wait=%b busdir_high=%b, required 0 1", sw, bh);
    end
    exp_q.push_back({3'b101, 8'h55});
    io_write(8'hC5, 8'h55, sw, bh, rel);
    n_cmp++;
    if ({sw, bh} !== 2'b01) begin
      n_err++;
      $display("FAIL fm_wr_c5: got saw_wait=%b busdir_high=%b, required 0 1", sw, bh);
    end
    drain();
    n_cmp++;
    if (wr_cnt - base !== 2) begin
      n_err++;
      $display("FAIL fm_wr_count: got %0d OPL4 writes, required 2", wr_cnt - base);
    end
  endtask

  task automatic test_back_to_back();
    logic sw, bh;
    int rel, base;
    logic [7:0] d;
    base = wr_cnt;
    for (int k = 0; k < 5; k++) begin
      d = 8'h30 + 8'(k);
      exp_q.push_back({3'b101, d});
      io_write(8'hC5, d, sw, bh, rel);
      n_cmp++;
      if (sw !== (k == 4)) begin
        n_err++;
        $display("FAIL b2b_wait_%0d: got saw_wait=%b, required %b", k, sw, k == 4);
      end
      if (k == 4) begin
        n_cmp++;
        if (rel !== base + 1) begin
          n_err++;
          $display("FAIL b2b_release: got %0d OPL4 writes at wait release, required 1", rel - base);
        end
      end
    end
    drain();
    n_cmp++;
    if (wr_cnt - base !== 5) begin
      n_err++;
      $display("FAIL b2b_count: got %0d OPL4 writes, required 5", wr_cnt - base);
    end
  endtask

  task automatic test_read();
    logic sw, bh, all_lo, any_lo, after;
    logic [7:0] d, dh;
    int rel, base;
    base = rd_cnt;
    exp_q.push_back({3'b101, 8'hAA});
    io_write(8'hC5, 8'hAA, sw, bh, rel);
    rd_exp_a = 3'b100;
    y_d_in = 8'h80;
    io_read(8'hC4, d, dh, sw, all_lo, any_lo, after);
    n_cmp++;
    if ({d, dh} !== {8'h80, 8'h80}) begin
      n_err++;
      $display("FAIL read_c4_data: got %h held %h, required 80 80", d, dh);
    end
    n_cmp++;
    if ({sw, all_lo, after} !== 3'b111) begin
      n_err++;
      $display("FAIL read_c4_bus: got saw_wait=%b busdir_low=%b busdir_after=%b, required 1 1 1", sw, all_lo, after);
    end
    rd_exp_a = 3'b110;
    y_d_in = 8'h3C;
    io_read(8'hC6, d, dh, sw, all_lo, any_lo, after);
    n_cmp++;
    if ({d, dh, sw} !== {8'h3C, 8'h3C, 1'b1}) begin
      n_err++;
      $display("FAIL read_c6: got data=%h held=%h saw_wait=%b, required 3c 3c 1", d, dh, sw);
    end
    drain();
    n_cmp++;
    if (rd_cnt - base !== 2) begin
      n_err++;
      $display("FAIL read_count: got %0d OPL4 reads, required 2", rd_cnt - base);
    end
  endtask

  task automatic test_wave();
    logic sw, bh;
    int rel, base, n_exp;
    base = cs_cnt;
`ifdef OPL4_WAVE_PORTS_EN
    n_exp = 1;
    exp_q.push_back({3'b001, 8'h12});
`else
    n_exp = 0;
`endif
    io_write(8'h7F, 8'h12, sw, bh, rel);
    n_cmp++;
    if (sw !== 1'b0) begin
      n_err++;
      $display("FAIL wave_wait: got saw_wait=%b, required 0", sw);
    end
    drain();
    n_cmp++;
    if (cs_cnt - base !== n_exp) begin
      n_err++;
      $display("FAIL wave_activity: got %0d OPL4 cycles, required %0d", cs_cnt - base, n_exp);
    end
  endtask

  task automatic test_undecoded();
    logic sw, bh, all_lo, any_lo, after;
    logic [7:0] d, dh;
    int rel, base;
    base = cs_cnt;
    io_write(8'h40, 8'hFF, sw, bh, rel);
    n_cmp++;
    if ({sw, bh} !== 2'b01) begin
      n_err++;
      $display("FAIL undec_write: got saw_wait=%b busdir_high=%b, required 0 1", sw, bh);
    end
    io_read(8'h40, d, dh, sw, all_lo, any_lo, after);
    n_cmp++;
    if ({sw, any_lo, d} !== {2'b00, 8'h3C}) begin
      n_err++;
      $display("FAIL undec_read: got saw_wait=%b busdir_low=%b d_out=%h, required 0 0 3c", sw, any_lo, d);
    end
    drain();
    n_cmp++;
    if (cs_cnt - base !== 0) begin
      n_err++;
      $display("FAIL undec_activity: got %0d OPL4 cycles, required 0", cs_cnt - base);
    end
  endtask

  task automatic test_reset_mid();
    logic sw, bh;
    int rel, base;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back({3'b101, 8'hA0 + 8'(k)});
      io_write(8'hC5, 8'hA0 + 8'(k), sw, bh, rel);
    end
    for (int i = 0; i < 200 && y_wr_n; i++) tick();
    n_cmp++;
    if ({y_wr_n, 32'(exp_q.size())} !== {1'b0, 32'd3}) begin
      n_err++;
      $display("FAIL midrst_setup: got wr_n=%b buffered=%0d, required 0 3", y_wr_n, exp_q.size());
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({y_cs_n, y_wr_n, y_rd_n, y_d_oe, msx_wait_n} !== 5'b11101) begin
      n_err++;
      $display("FAIL midrst_abort: got cs_n=%b wr_n=%b rd_n=%b oe=%b wait_n=%b, required 1 1 1 0 1",
               y_cs_n, y_wr_n, y_rd_n, y_d_oe, msx_wait_n);
    end
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    base = cs_cnt;
    repeat (200) tick();
    n_cmp++;
    if ({32'(cs_cnt - base), msx_wait_n} !== {32'd0, 1'b1}) begin
      n_err++;
      $display("FAIL midrst_flushed: got %0d OPL4 cycles wait_n=%b, required 0 1", cs_cnt - base, msx_wait_n);
    end
  endtask

  initial begin
    test_reset();
    test_fm_writes();
    test_back_to_back();
    test_read();
    test_wave();
    test_undecoded();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1);
  end
endmodule
